// File: rtl/if_fsm.sv
// rtl/if_fsm.sv - 6502 instruction fetch FSM with its opcode attribute table.
// Reads opcode/operands/pointers over a fixed-latency bus and resolves the effective address.
module op_attr_table (
  input  logic [7:0] i_op,
  output logic [3:0] o_mode,
  output logic [7:0] o_simple_op,
  output logic [3:0] o_alu_op,
  output logic [2:0] o_store_flag,
  output logic [1:0] o_reg_load_flag,
  output logic       o_mem_load_flag
);
  localparam logic [3:0] M_IMP = 4'd0, M_IMM = 4'd1, M_ZP = 4'd2, M_ZPX = 4'd3, M_ZPY = 4'd4,
    M_REL = 4'd5, M_ABS = 4'd6, M_ABSX = 4'd7, M_ABSY = 4'd8, M_INDX = 4'd9, M_INDY = 4'd10,
    M_IND = 4'd11;
  localparam logic [7:0] C_NOP = 8'd0, C_ALU = 8'd1, C_LOAD = 8'd2, C_STORE = 8'd3,
    C_RMW = 8'd4, C_BRANCH = 8'd5, C_JUMP = 8'd6, C_MISC = 8'd7;

  logic [2:0] w_aaa, w_bbb;
  logic [1:0] w_cc;
  logic [3:0] w_mode;
  logic       w_legal, w_mem_mode, w_imp;

  assign w_aaa = i_op[7:5];
  assign w_bbb = i_op[4:2];
  assign w_cc  = i_op[1:0];

  // Addressing mode follows the aaa/bbb/cc opcode grid; holes in the grid fall back to NOP.
  always_comb begin
    w_mode  = M_IMP;
    w_legal = 1'b1;
    case (w_cc)
      2'b01: begin
        w_legal = (i_op != 8'h89);
        case (w_bbb)
          3'd0:    w_mode = M_INDX;
          3'd1:    w_mode = M_ZP;
          3'd2:    w_mode = M_IMM;
          3'd3:    w_mode = M_ABS;
          3'd4:    w_mode = M_INDY;
          3'd5:    w_mode = M_ZPX;
          3'd6:    w_mode = M_ABSY;
          default: w_mode = M_ABSX;
        endcase
      end
      2'b10: begin
        case (w_bbb)
          3'd0: begin w_mode = M_IMM; w_legal = (w_aaa == 3'd5); end
          3'd1: w_mode = M_ZP;
          3'd3: w_mode = M_ABS;
          3'd4: w_legal = 1'b0;
          3'd5: w_mode = (w_aaa[2:1] == 2'b10) ? M_ZPY : M_ZPX;
          3'd6: w_legal = (w_aaa[2:1] == 2'b10);
          3'd7: begin w_mode = (w_aaa == 3'd5) ? M_ABSY : M_ABSX; w_legal = (w_aaa != 3'd4); end
          default: w_mode = M_IMP;
        endcase
      end
      2'b00: begin
        case (w_bbb)
          3'd0: begin
            w_legal = (w_aaa != 3'd4);
            w_mode  = (w_aaa == 3'd1) ? M_ABS : (w_aaa[2] ? M_IMM : M_IMP);
          end
          3'd1: begin w_mode = M_ZP; w_legal = w_aaa[2] || (w_aaa == 3'd1); end
          3'd3: begin w_mode = (w_aaa == 3'd3) ? M_IND : M_ABS; w_legal = (w_aaa != 3'd0); end
          3'd4: w_mode = M_REL;
          3'd5: begin w_mode = M_ZPX; w_legal = (w_aaa[2:1] == 2'b10); end
          3'd7: begin w_mode = M_ABSX; w_legal = (w_aaa == 3'd5); end
          default: w_mode = M_IMP;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) w_mode = M_IMP;
  end

  assign w_imp      = (w_mode == M_IMP);
  assign w_mem_mode = ((w_mode >= M_ZP) && (w_mode <= M_ZPY)) || ((w_mode >= M_ABS) && (w_mode <= M_INDY));

  // Store codes: 1=A 2=X 3=Y 4=memory 5=SP; register-load codes: 1=A 2=X 3=Y.
  always_comb begin
    o_simple_op     = C_NOP;
    o_alu_op        = 4'd0;
    o_store_flag    = 3'd0;
    o_reg_load_flag = 2'd0;
    if (w_legal && i_op != 8'hEA) begin
      case (w_cc)
        2'b01: begin
          o_alu_op = {1'b0, w_aaa};
          if (w_aaa == 3'd4) begin
            o_simple_op = C_STORE; o_store_flag = 3'd4; o_reg_load_flag = 2'd1;
          end else if (w_aaa == 3'd5) begin
            o_simple_op = C_LOAD; o_store_flag = 3'd1;
          end else begin
            o_simple_op = C_ALU; o_store_flag = (w_aaa == 3'd6) ? 3'd0 : 3'd1;
          end
        end
        2'b10: begin
          if (w_aaa == 3'd4) begin
            o_simple_op = w_imp ? C_MISC : C_STORE; o_reg_load_flag = 2'd2;
            o_store_flag = w_imp ? ((i_op == 8'h9A) ? 3'd5 : 3'd1) : 3'd4;
          end else if (w_aaa == 3'd5) begin
            o_simple_op = w_imp ? C_MISC : C_LOAD; o_store_flag = 3'd2;
            o_reg_load_flag = w_imp ? 2'd1 : 2'd0;
          end else begin
            o_simple_op = C_RMW; o_alu_op = {1'b1, w_aaa};
            o_store_flag = w_imp ? (w_aaa[2] ? 3'd2 : 3'd1) : 3'd4;
          end
        end
        default: begin
          if (w_mode == M_REL) o_simple_op = C_BRANCH;
          else if (i_op == 8'h20 || i_op == 8'h4C || i_op == 8'h6C) o_simple_op = C_JUMP;
          else if (w_imp) o_simple_op = C_MISC;
          else if (w_aaa == 3'd4) begin
            o_simple_op = C_STORE; o_store_flag = 3'd4; o_reg_load_flag = 2'd3;
          end else if (w_aaa == 3'd5) begin
            o_simple_op = C_LOAD; o_store_flag = 3'd3;
          end else begin
            o_simple_op = C_ALU; o_alu_op = (w_aaa == 3'd1) ? 4'd1 : 4'd6;
          end
        end
      endcase
    end
  end

  assign o_mode          = w_mode;
  assign o_mem_load_flag = w_mem_mode &&
    (o_simple_op == C_ALU || o_simple_op == C_LOAD || o_simple_op == C_RMW);
endmodule

module if_fsm #(
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_start,
  input  logic [15:0] pc_in,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  output logic [15:0] mem_addr,
  output logic        mem_read_en,
  input  logic [7:0]  mem_data_in,
  output logic        if_ready,
  output logic [15:0] if_addr_out,
  output logic [15:0] if_pc_next,
  output logic [7:0]  simple_op,
  output logic [3:0]  alu_op,
  output logic [2:0]  store_flag,
  output logic [1:0]  reg_load_flag,
  output logic        mem_load_flag,
  output logic        immediate_flag
);
  localparam logic [3:0] M_IMP = 4'd0, M_IMM = 4'd1, M_ZP = 4'd2, M_ZPX = 4'd3, M_ZPY = 4'd4,
    M_REL = 4'd5, M_ABS = 4'd6, M_ABSX = 4'd7, M_ABSY = 4'd8, M_INDX = 4'd9, M_INDY = 4'd10,
    M_IND = 4'd11;
  localparam int CW = $clog2(READ_LAT + 2);
  localparam logic [CW-1:0] CAP = CW'(READ_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_OP, S_FETCH_LO, S_FETCH_HI, S_PTR_LO, S_PTR_HI, S_DONE
  } state_t;

  state_t      r_state, w_next_state;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_pc, r_addr_out, r_pc_next, w_ea, w_len;
  logic [7:0]  r_op, r_b1, r_hi, r_lo, r_simple_op;
  logic [3:0]  r_alu_op, w_mode, w_alu_op;
  logic [2:0]  r_store_flag, w_store_flag;
  logic [1:0]  r_reg_load_flag, w_reg_load_flag;
  logic        r_ready, r_mem_load, r_imm, w_mem_load, w_cap;
  logic [7:0]  w_op_byte, w_simple_op, w_sum_x, w_sum_y, w_ptr_lo, w_ptr_lo1;

  // The opcode is decoded straight off the bus in its capture cycle, from r_op afterwards.
  assign w_op_byte = (r_state == S_FETCH_OP) ? mem_data_in : r_op;
  assign w_cap     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_cnt == CAP);
  assign w_sum_x   = mem_data_in + x_in;
  assign w_sum_y   = mem_data_in + y_in;
  assign w_ptr_lo  = r_b1 + ((w_mode == M_INDX) ? x_in : 8'h00);
  assign w_ptr_lo1 = w_ptr_lo + 8'd1;

  op_attr_table u_attr (
    .i_op(w_op_byte), .o_mode(w_mode), .o_simple_op(w_simple_op), .o_alu_op(w_alu_op),
    .o_store_flag(w_store_flag), .o_reg_load_flag(w_reg_load_flag), .o_mem_load_flag(w_mem_load)
  );

  // FETCH_OP spends one cycle before its issue; later reads were issued in the prior capture cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) r_cnt <= (w_next_state == S_FETCH_OP) ? '0 : CW'(2);
      else if (r_cnt != CAP) r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (if_start) w_next_state = S_FETCH_OP;
      S_FETCH_OP: if (w_cap) w_next_state = (w_mode == M_IMP) ? S_DONE : S_FETCH_LO;
      S_FETCH_LO: if (w_cap) begin
        if (w_mode == M_INDX || w_mode == M_INDY) w_next_state = S_PTR_LO;
        else if ((w_mode >= M_ABS && w_mode <= M_ABSY) || w_mode == M_IND) w_next_state = S_FETCH_HI;
        else w_next_state = S_DONE;
      end
      S_FETCH_HI: if (w_cap) w_next_state = (w_mode == M_IND) ? S_PTR_LO : S_DONE;
      S_PTR_LO:   if (w_cap) w_next_state = S_PTR_HI;
      S_PTR_HI:   if (w_cap) w_next_state = S_DONE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read_en = 1'b0;
    mem_addr    = 16'h0000;
    if (r_state == S_FETCH_OP && r_cnt == CW'(1)) begin
      mem_read_en = 1'b1;
      mem_addr    = r_pc;
    end else if (w_cap && w_next_state != S_DONE) begin
      mem_read_en = 1'b1;
      case (w_next_state)
        S_FETCH_LO: mem_addr = r_pc + 16'd1;
        S_FETCH_HI: mem_addr = r_pc + 16'd2;
        S_PTR_LO:   mem_addr = (w_mode == M_IND) ? {mem_data_in, r_b1}
                             : {8'h00, (w_mode == M_INDX) ? w_sum_x : mem_data_in};
        default:    mem_addr = {(w_mode == M_IND) ? r_hi : 8'h00, w_ptr_lo1};
      endcase
    end
  end

  always_comb begin
    w_ea  = 16'h0000;
    w_len = 16'd2;
    case (w_mode)
      M_IMM, M_ZP: w_ea = {8'h00, mem_data_in};
      M_ZPX:       w_ea = {8'h00, w_sum_x};
      M_ZPY:       w_ea = {8'h00, w_sum_y};
      M_REL:       w_ea = r_pc + 16'd2 + {{8{mem_data_in[7]}}, mem_data_in};
      M_ABS:       begin w_ea = {mem_data_in, r_b1}; w_len = 16'd3; end
      M_ABSX:      begin w_ea = {mem_data_in, r_b1} + {8'h00, x_in}; w_len = 16'd3; end
      M_ABSY:      begin w_ea = {mem_data_in, r_b1} + {8'h00, y_in}; w_len = 16'd3; end
      M_INDX:      w_ea = {mem_data_in, r_lo};
      M_INDY:      w_ea = {mem_data_in, r_lo} + {8'h00, y_in};
      M_IND:       begin w_ea = {mem_data_in, r_lo}; w_len = 16'd3; end
      default:     w_len = 16'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0; r_op <= '0; r_b1 <= '0; r_hi <= '0; r_lo <= '0;
      r_ready <= 1'b0; r_addr_out <= '0; r_pc_next <= '0; r_simple_op <= '0;
      r_alu_op <= '0; r_store_flag <= '0; r_reg_load_flag <= '0; r_mem_load <= 1'b0; r_imm <= 1'b0;
    end else begin
      if (r_state == S_IDLE && if_start) begin
        r_pc    <= pc_in;
        r_ready <= 1'b0;
      end
      if (w_cap) begin
        case (r_state)
          S_FETCH_OP: r_op <= mem_data_in;
          S_FETCH_LO: r_b1 <= mem_data_in;
          S_FETCH_HI: r_hi <= mem_data_in;
          S_PTR_LO:   r_lo <= mem_data_in;
          default:    ;
        endcase
      end
      if (w_cap && w_next_state == S_DONE) begin
        r_ready         <= 1'b1;
        r_addr_out      <= w_ea;
        r_pc_next       <= r_pc + w_len;
        r_simple_op     <= w_simple_op;
        r_alu_op        <= w_alu_op;
        r_store_flag    <= w_store_flag;
        r_reg_load_flag <= w_reg_load_flag;
        r_mem_load      <= w_mem_load;
        r_imm           <= (w_mode == M_IMM);
      end
    end
  end

  assign if_ready       = r_ready;
  assign if_addr_out    = r_addr_out;
  assign if_pc_next     = r_pc_next;
  assign simple_op      = r_simple_op;
  assign alu_op         = r_alu_op;
  assign store_flag     = r_store_flag;
  assign reg_load_flag  = r_reg_load_flag;
  assign mem_load_flag  = r_mem_load;
  assign immediate_flag = r_imm;
endmodule

// File: tb/tb_if_fsm.sv
// tb/tb_if_fsm.sv - directed bench for if_fsm against a fixed-latency memory model.
module tb_if_fsm;
  localparam int LAT = 2;

  logic        clk = 1'b0, rst = 1'b1, if_start = 1'b0;
  logic [15:0] pc_in = '0, mem_addr, if_addr_out, if_pc_next;
  logic [7:0]  x_in = '0, y_in = '0, mem_data_in, simple_op;
  logic        mem_read_en, if_ready, mem_load_flag, immediate_flag;
  logic [3:0]  alu_op;
  logic [2:0]  store_flag;
  logic [1:0]  reg_load_flag;

  logic [7:0]  mem [0:65535];
  logic [15:0] pa [LAT];
  logic        pv [LAT];
  logic [15:0] rd_q [$];
  int          rd_count = 0;
  int          n_checks = 0, n_fail = 0;
  int          rc;

  if_fsm #(.READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .if_start(if_start), .pc_in(pc_in), .x_in(x_in), .y_in(y_in),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_data_in(mem_data_in),
    .if_ready(if_ready), .if_addr_out(if_addr_out), .if_pc_next(if_pc_next),
    .simple_op(simple_op), .alu_op(alu_op), .store_flag(store_flag),
    .reg_load_flag(reg_load_flag), .mem_load_flag(mem_load_flag), .immediate_flag(immediate_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pa[0] <= mem_addr;
    pv[0] <= mem_read_en;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pv[i] <= pv[i-1];
    end
    if (mem_read_en) begin
      rd_count <= rd_count + 1;
      rd_q.push_back(mem_addr);
    end
  end

  assign mem_data_in = pv[LAT-1] ? mem[pa[LAT-1]] : 8'hEE;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cycle k is observed at the falling edge after the k-th rising edge past the one sampling if_start.
  task automatic do_fetch(input logic [15:0] pc, input logic [7:0] x, input logic [7:0] y,
                          input int restart_at, input int rst_at, output int rdy_cyc);
    @(negedge clk);
    pc_in = pc; x_in = x; y_in = y; if_start = 1'b1;
    rd_count = 0;
    rd_q.delete();
    @(negedge clk);
    if_start = 1'b0;
    rdy_cyc = -1;
    for (int k = 0; k < 40; k++) begin
      if (if_ready) begin
        rdy_cyc = k;
        break;
      end
      if_start = (k == restart_at);
      if (k == restart_at) pc_in = 16'h9000;
      rst = (k == rst_at);
      @(negedge clk);
    end
    if_start = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    for (int i = 0; i < LAT; i++) begin pa[i] = '0; pv[i] = 1'b0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, if_ready}, 32'd0);
    check_eq("rst_rden", {31'd0, mem_read_en}, 32'd0);
    check_eq("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("rst_addr_out", {16'd0, if_addr_out}, 32'd0);
    check_eq("rst_pc_next", {16'd0, if_pc_next}, 32'd0);
    check_eq("rst_ops", {20'd0, simple_op, alu_op}, 32'd0);
    check_eq("rst_flags", {25'd0, store_flag, reg_load_flag, mem_load_flag, immediate_flag}, 32'd0);

    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    do_fetch(16'h8000, 8'h00, 8'h00, -1, -1, rc);
    check_eq("imm_cycle", 32'(rc), 32'd6);
    check_eq("imm_addr", {16'd0, if_addr_out}, 32'h0042);
    check_eq("imm_flag", {31'd0, immediate_flag}, 32'd1);
    check_eq("imm_memload", {31'd0, mem_load_flag}, 32'd0);
    check_eq("imm_pc_next", {16'd0, if_pc_next}, 32'h8002);
    check_eq("imm_reads", 32'(rd_count), 32'd2);

    mem[16'h8000] = 8'hB5; mem[16'h8001] = 8'hF0;
    do_fetch(16'h8000, 8'h20, 8'h00, -1, -1, rc);
    check_eq("zpx_addr", {16'd0, if_addr_out}, 32'h0010);
    check_eq("zpx_pc_next", {16'd0, if_pc_next}, 32'h8002);
    check_eq("zpx_memload", {31'd0, mem_load_flag}, 32'd1);
    check_eq("zpx_imm", {31'd0, immediate_flag}, 32'd0);

    mem[16'h8000] = 8'hB1; mem[16'h8001] = 8'hFF; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    do_fetch(16'h8000, 8'h00, 8'hFF, -1, -1, rc);
    check_eq("indy_cycle", 32'(rc), 32'd10);
    check_eq("indy_addr", {16'd0, if_addr_out}, 32'h1333);
    check_eq("indy_reads", 32'(rd_count), 32'd4);
    check_eq("indy_ptr_hi", {16'd0, (rd_q.size() > 3) ? rd_q[3] : 16'hDEAD}, 32'h0000);

    mem[16'h8000] = 8'hA1; mem[16'h8001] = 8'hFE;
    do_fetch(16'h8000, 8'h01, 8'h00, -1, -1, rc);
    check_eq("indx_cycle", 32'(rc), 32'd10);
    check_eq("indx_addr", {16'd0, if_addr_out}, 32'h1234);

    mem[16'h8000] = 8'h6C; mem[16'h8001] = 8'hFF; mem[16'h8002] = 8'h10;
    mem[16'h10FF] = 8'h00; mem[16'h1000] = 8'h90;
    do_fetch(16'h8000, 8'h00, 8'h00, -1, -1, rc);
    check_eq("jind_cycle", 32'(rc), 32'd12);
    check_eq("jind_addr", {16'd0, if_addr_out}, 32'h9000);
    check_eq("jind_pc_next", {16'd0, if_pc_next}, 32'h8003);
    check_eq("jind_hi_rd", {16'd0, (rd_q.size() > 4) ? rd_q[4] : 16'hDEAD}, 32'h1000);

    mem[16'h8010] = 8'hD0; mem[16'h8011] = 8'hFC;
    do_fetch(16'h8010, 8'h00, 8'h00, -1, -1, rc);
    check_eq("rel_back", {16'd0, if_addr_out}, 32'h800E);
    check_eq("rel_pc_next", {16'd0, if_pc_next}, 32'h8012);
    mem[16'h8011] = 8'h7F;
    do_fetch(16'h8010, 8'h00, 8'h00, -1, -1, rc);
    check_eq("rel_fwd", {16'd0, if_addr_out}, 32'h8091);

    mem[16'h8000] = 8'hEA;
    do_fetch(16'h8000, 8'h00, 8'h00, -1, -1, rc);
    check_eq("imp_cycle", 32'(rc), 32'd4);
    check_eq("imp_pc_next", {16'd0, if_pc_next}, 32'h8001);
    check_eq("imp_reads", 32'(rd_count), 32'd1);

    mem[16'h8000] = 8'h02;
    do_fetch(16'h8000, 8'h00, 8'h00, -1, -1, rc);
    check_eq("illegal_pc_next", {16'd0, if_pc_next}, 32'h8001);

    mem[16'h8000] = 8'hBD; mem[16'h8001] = 8'hFF; mem[16'h8002] = 8'h20;
    do_fetch(16'h8000, 8'h01, 8'h00, -1, -1, rc);
    check_eq("absx_addr", {16'd0, if_addr_out}, 32'h2100);

    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;
    do_fetch(16'hFFFF, 8'h00, 8'h00, -1, -1, rc);
    check_eq("wrap_addr", {16'd0, if_addr_out}, 32'h0077);
    check_eq("wrap_pc_next", {16'd0, if_pc_next}, 32'h0001);
    check_eq("wrap_opnd_rd", {16'd0, (rd_q.size() > 1) ? rd_q[1] : 16'hDEAD}, 32'h0000);

    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h00; mem[16'h8002] = 8'h20;
    do_fetch(16'h8000, 8'h00, 8'h00, 3, -1, rc);
    check_eq("restart_cycle", 32'(rc), 32'd8);
    check_eq("restart_addr", {16'd0, if_addr_out}, 32'h2000);
    check_eq("restart_pc_next", {16'd0, if_pc_next}, 32'h8003);
    check_eq("restart_reads", 32'(rd_count), 32'd3);

    do_fetch(16'h8000, 8'h00, 8'h00, -1, 4, rc);
    check_eq("rst_mid_ready", 32'(rc), 32'hFFFF_FFFF);
    check_eq("rst_mid_reads", 32'(rd_count), 32'd2);
    check_eq("rst_mid_addr_out", {16'd0, if_addr_out}, 32'd0);
    check_eq("rst_mid_rden", {31'd0, mem_read_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
